// File: rtl/gf_sclw_pipe_if.sv
// Beat-level handshake bundle for gf_sclw_pipe: upstream operand/mode beats in,
// scaled result beats out, each side with its own valid/ready pair.
interface gf_sclw_pipe_if #(
    parameter int unsigned LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_mode;
    logic [2*LANES-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_mode;
    logic [2*LANES-1:0]   out_data;

    // The pipeline block sits on the slave side.
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data
    );

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data
    );
endinterface

// File: rtl/gf_sclw_pipe.sv
// Per-lane GF(2^2) identity / xOmega / xOmega^2 / square in normal basis
// [Omega^2, Omega], registered through DEPTH valid/ready pipeline stages.
module gf_sclw_pipe #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    gf_sclw_pipe_if.slave   pipe_if
);
    localparam int unsigned DW = 2 * LANES;

    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [1:0]       mode_q [DEPTH];
    logic [1:0]       mode_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic             in_ready_c;
    logic [DW-1:0]    op_data;

    // Element {a1,a0} = a1*Omega^2 + a0*Omega.
    function automatic logic [1:0] lane_op(input logic [1:0] m, input logic [1:0] a);
        logic [1:0] q;
        case (m)
            2'b00:   q = a;
            2'b01:   q = {a[1] ^ a[0], a[1]};
            2'b10:   q = {a[0], a[1] ^ a[0]};
            default: q = {a[0], a[1]};
        endcase
        return q;
    endfunction

    always_comb begin
        op_data = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            op_data[2*i +: 2] = lane_op(pipe_if.in_mode, pipe_if.in_data[2*i +: 2]);
        end
    end

    // Advance chain resolved from the output end back to stage 0.
    always_comb begin
        adv = '0;
        load = '0;
        adv[DEPTH-1] = v_q[DEPTH-1] & pipe_if.out_ready;
        for (int s = int'(DEPTH) - 2; s >= 0; s--) begin
            adv[s] = v_q[s] & (~v_q[s+1] | adv[s+1]);
        end
        in_ready_c = ~v_q[0] | adv[0];
        load[0] = pipe_if.in_valid & in_ready_c;
        for (int s = 1; s < int'(DEPTH); s++) begin
            load[s] = adv[s-1];
        end
        v_d = (v_q & ~adv) | load;
    end

    always_comb begin
        data_d = data_q;
        mode_d = mode_q;
        if (load[0]) begin
            data_d[0] = op_data;
            mode_d[0] = pipe_if.in_mode;
        end
        for (int s = 1; s < int'(DEPTH); s++) begin
            if (load[s]) begin
                data_d[s] = data_q[s-1];
                mode_d[s] = mode_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int s = 0; s < int'(DEPTH); s++) begin
                data_q[s] <= '0;
                mode_q[s] <= '0;
            end
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            mode_q <= mode_d;
        end
    end

    assign pipe_if.in_ready  = in_ready_c;
    assign pipe_if.out_valid = v_q[DEPTH-1];
    assign pipe_if.out_data  = data_q[DEPTH-1];
    assign pipe_if.out_mode  = mode_q[DEPTH-1];
endmodule

// File: tb/tb_gf_sclw_pipe.sv
// Bench for gf_sclw_pipe: three configurations checked every cycle against a
// GF(4) power-of-Omega model and a beat queue, plus directed literal checks.
module tb_gf_sclw_pipe;
    localparam int NI = 3;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic [15:0] data;
    } beat_t;

    function automatic int lanes_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : 8;
    endfunction

    function automatic int depth_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 3;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic              iv   [NI];
    logic [1:0]        im   [NI];
    logic [15:0]       id   [NI];
    logic              ordy [NI];
    logic [NI-1:0]     ir_v;
    logic [NI-1:0]     ov_v;
    logic [2*NI-1:0]   om_v;
    logic [16*NI-1:0]  od_v;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 4 : (g == 1) ? 1 : 8;
        localparam int unsigned D = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        gf_sclw_pipe_if #(.LANES(L)) bus ();
        gf_sclw_pipe #(.LANES(L), .DEPTH(D)) u_dut (.clk(clk), .rst(rst), .pipe_if(bus));
        assign bus.in_valid  = iv[g];
        assign bus.in_mode   = im[g];
        assign bus.in_data   = id[g][2*L-1:0];
        assign bus.out_ready = ordy[g];
        assign ir_v[g]            = bus.in_ready;
        assign ov_v[g]            = bus.out_valid;
        assign om_v[2*g +: 2]     = bus.out_mode;
        assign od_v[16*g +: 16]   = 16'(bus.out_data);
    end

    int          checks = 0;
    int          errors = 0;
    int          out_cnt0 = 0;
    beat_t       q [NI][$];
    logic        prev_stall [NI];
    logic [15:0] prev_d [NI];
    logic [1:0]  prev_m [NI];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Each nonzero element is Omega^p with p in {0,1,2}; 11 = 1, 01 = Omega, 10 = Omega^2.
    function automatic logic [15:0] model(input logic [1:0] m, input logic [15:0] d, input int lanes);
        logic [15:0] r;
        logic [1:0]  e;
        int          p;
        r = '0;
        for (int i = 0; i < lanes; i++) begin
            e = d[2*i +: 2];
            if (e != 2'b00) begin
                p = (e == 2'b01) ? 1 : (e == 2'b10) ? 2 : 0;
                case (m)
                    2'd0:    p = p;
                    2'd1:    p = p + 1;
                    2'd2:    p = p + 2;
                    default: p = 2 * p;
                endcase
                p = p % 3;
                r[2*i +: 2] = (p == 0) ? 2'b11 : (p == 1) ? 2'b01 : 2'b10;
            end
        end
        return r;
    endfunction

    // Per-cycle scoreboard for every instance, sampled with inputs settled before the edge.
    task automatic mon();
        beat_t       b;
        logic [15:0] mask;
        logic [15:0] od;
        logic [1:0]  om;
        for (int g = 0; g < NI; g++) begin
            od = od_v[16*g +: 16];
            om = om_v[2*g +: 2];
            if (rst) begin
                q[g].delete();
                prev_stall[g] = 1'b0;
                continue;
            end
            chk($sformatf("in_ready[%0d]", g), 32'(ir_v[g]),
                32'((q[g].size() < depth_of(g)) || ordy[g]));
            if (q[g].size() == 0) chk($sformatf("empty_out_valid[%0d]", g), 32'(ov_v[g]), 32'd0);
            if (prev_stall[g]) begin
                chk($sformatf("hold_valid[%0d]", g), 32'(ov_v[g]), 32'd1);
                chk($sformatf("hold_data[%0d]", g), 32'(od), 32'(prev_d[g]));
                chk($sformatf("hold_mode[%0d]", g), 32'(om), 32'(prev_m[g]));
            end
            if (ov_v[g] && ordy[g]) begin
                if (q[g].size() == 0) begin
                    chk($sformatf("unexpected_beat[%0d]", g), 32'(od), 32'hFFFF_FFFF);
                end else begin
                    b = q[g].pop_front();
                    chk($sformatf("out_data[%0d]", g), 32'(od), 32'(b.data));
                    chk($sformatf("out_mode[%0d]", g), 32'(om), 32'(b.mode));
                    chk($sformatf("min_latency[%0d]", g), 32'(cyc - b.cyc), 32'(cyc - b.cyc >= depth_of(g) ? cyc - b.cyc : depth_of(g)));
                end
                if (g == 0) out_cnt0++;
            end
            prev_stall[g] = ov_v[g] && !ordy[g];
            prev_d[g] = od;
            prev_m[g] = om;
            if (iv[g] && ir_v[g]) begin
                mask = 16'((32'd1 << (2 * lanes_of(g))) - 32'd1);
                b.cyc  = cyc;
                b.mode = im[g];
                b.data = model(im[g], id[g] & mask, lanes_of(g));
                q[g].push_back(b);
            end
        end
    endtask

    task automatic step(input logic v, input logic [1:0] m, input logic [15:0] d, input logic r);
        @(negedge clk);
        iv[0] = v; im[0] = m; id[0] = d; ordy[0] = r;
        for (int g = 1; g < NI; g++) begin
            iv[g] = 1'b0; ordy[g] = 1'b1;
        end
        #1;
        mon();
    endtask

    // One beat through instance 0 with out_ready high; returns its result.
    task automatic run_one(input logic [1:0] m, input logic [15:0] d, output logic [15:0] res);
        int found;
        found = 0;
        res = '0;
        step(1'b1, m, d, 1'b1);
        chk("run_one_accept", 32'(ir_v[0]), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 2'd0, 16'd0, 1'b1);
            if (ov_v[0]) begin
                found = k;
                res = od_v[15:0];
                break;
            end
        end
        chk("run_one_latency", 32'(found), 32'd2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp1 [4];
        logic [15:0] r1, r2, r3;
        logic [15:0] bdat;
        int          acc, base_cnt;

        exp1[0] = 8'hE4; exp1[1] = 8'h78; exp1[2] = 8'h9C; exp1[3] = 8'hD8;
        for (int g = 0; g < NI; g++) begin
            iv[g] = 1'b0; im[g] = 2'd0; id[g] = 16'd0; ordy[g] = 1'b1;
            prev_stall[g] = 1'b0; prev_d[g] = '0; prev_m[g] = '0;
        end

        step(1'b0, 2'd0, 16'd0, 1'b0);
        chk("reset_out_valid", 32'(ov_v[0]), 32'd0);
        chk("reset_in_ready", 32'(ir_v[0]), 32'd1);
        chk("reset_out_data", 32'(od_v[15:0]), 32'd0);
        chk("reset_out_mode", 32'(om_v[1:0]), 32'd0);
        #2 rst = 1'b0;

        // Four modes back to back on 8'hE4.
        for (int j = 0; j < 6; j++) begin
            step(j < 4, 2'(j), 16'h00E4, 1'b1);
            chk("stream_in_ready", 32'(ir_v[0]), 32'd1);
            if (j >= 2) begin
                chk("stream_out_valid", 32'(ov_v[0]), 32'd1);
                chk("stream_out_data", 32'(od_v[15:0]), 32'(exp1[j-2]));
                chk("stream_out_mode", 32'(om_v[1:0]), 32'(j - 2));
            end else begin
                chk("stream_pre_valid", 32'(ov_v[0]), 32'd0);
            end
        end

        // xOmega three times returns the operand.
        run_one(2'd1, 16'h00E4, r1);
        chk("cyclic_1", 32'(r1), 32'h78);
        run_one(2'd1, r1, r2);
        chk("cyclic_2", 32'(r2), 32'h9C);
        run_one(2'd1, r2, r3);
        chk("cyclic_3", 32'(r3), 32'hE4);

        // Backpressure: six beats offered against a stalled sink.
        base_cnt = out_cnt0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            bdat = 16'(8'(8'h35 * (acc + 1)));
            step(1'b1, 2'(acc % 4), bdat, 1'b0);
            if (ir_v[0]) acc++;
            if (c >= 2) chk("bp_in_ready_low", 32'(ir_v[0]), 32'd0);
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        chk("bp_head_data", 32'(od_v[15:0]), 32'h35);
        bdat = 16'(8'(8'h35 * (acc + 1)));
        step(1'b1, 2'(acc % 4), bdat, 1'b1);
        chk("full_swap_in_ready", 32'(ir_v[0]), 32'd1);
        chk("full_swap_out_valid", 32'(ov_v[0]), 32'd1);
        if (ir_v[0]) acc++;
        bdat = 16'(8'(8'h35 * (acc + 1)));
        step(1'b1, 2'(acc % 4), bdat, 1'b1);
        chk("full_swap_no_bubble", 32'(ov_v[0]), 32'd1);
        if (ir_v[0]) acc++;
        for (int c = 0; c < 20; c++) begin
            bdat = 16'(8'(8'h35 * (acc + 1)));
            step(acc < 6, 2'(acc % 4), bdat, 1'b1);
            if (acc < 6 && ir_v[0]) acc++;
        end
        chk("bp_total_in", 32'(acc), 32'd6);
        chk("bp_total_out", 32'(out_cnt0 - base_cnt), 32'd6);

        // Asynchronous reset with two beats in flight.
        step(1'b1, 2'd0, 16'h0055, 1'b0);
        step(1'b1, 2'd1, 16'h00AA, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(ov_v[0]), 32'd0);
        chk("arst_out_data", 32'(od_v[15:0]), 32'd0);
        chk("arst_out_mode", 32'(om_v[1:0]), 32'd0);
        chk("arst_in_ready", 32'(ir_v[0]), 32'd1);
        step(1'b0, 2'd0, 16'd0, 1'b1);
        #3 rst = 1'b0;
        run_one(2'd1, 16'h0001, r1);
        chk("post_reset_data", 32'(r1), 32'h02);

        // Random traffic on all three configurations.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                iv[g]   = ($urandom_range(0, 3) != 0);
                ordy[g] = ($urandom_range(0, 2) != 0);
                im[g]   = 2'($urandom_range(0, 3));
                id[g]   = 16'($urandom);
            end
            #1;
            mon();
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                iv[g] = 1'b0; ordy[g] = 1'b1;
            end
            #1;
            mon();
        end
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("drained[%0d]", g), 32'(q[g].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
